pipeline_ctrl: RTL

Pipeline stall/flush controller for the 5-stage MIPS32 core. It collects hazard requests from ID (load-use), EX (multi-cycle ops such as DIV/MADD) and MEM (exception/branch flush). It drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the bubble and flush controls. It owns a cycle counter that sequences multi-cycle EX operations, so the EX unit only issues a start pulse with a cycle count. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline: arbitrates flush, multi-cycle EX
// occupancy and load-use hazards, and keeps a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_load_use,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic             ex_mc_last,
  output logic             ex_mc_abort,
  output logic [31:0]      stall_cycles
);

  typedef enum logic {RUN = 1'b0, MC = 1'b1} state_t;

  localparam logic [5:0]       STALL_MC = 6'b001111;
  localparam logic [5:0]       STALL_LU = 6'b000111;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (stall[0] && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  // Outputs are combinational so a hazard is honoured in the cycle it is raised.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    stall        = '0;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;
    ex_mc_last   = 1'b0;
    ex_mc_abort  = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (flush_req) begin
            flush = 1'b1;
          end else if (ex_mc_start) begin
            if (ex_mc_cycles == CNT_TWO) begin
              stall      = STALL_MC;
              ex_mc_last = 1'b1;
            end else if (ex_mc_cycles > CNT_TWO) begin
              stall       = STALL_MC;
              w_cnt_nxt   = ex_mc_cycles - CNT_TWO;
              w_state_nxt = MC;
            end
          end else if (id_load_use) begin
            stall        = STALL_LU;
            id_ex_bubble = 1'b1;
          end
        end
        MC: begin
          if (flush_req) begin
            flush       = 1'b1;
            ex_mc_abort = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            stall = STALL_MC;
            // cnt of 0 is unreachable; treating it as last keeps the FSM from wrapping.
            if (r_cnt <= CNT_ONE) begin
              ex_mc_last  = 1'b1;
              w_state_nxt = RUN;
            end else begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
